// File: rtl/dff_universal_reg.sv
// WIDTH-bit storage register with load/shift/rotate/toggle/set/clear modes,
// complementary outputs and a saturating count of edges on which Q changed.
module dff_universal_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             Sin,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             Sout,
  output logic             Changed,
  output logic [CNT_W-1:0] Chg_cnt
);

  localparam logic [2:0] M_HOLD   = 3'b000;
  localparam logic [2:0] M_LOAD   = 3'b001;
  localparam logic [2:0] M_SHL    = 3'b010;
  localparam logic [2:0] M_SHR    = 3'b011;
  localparam logic [2:0] M_TOGGLE = 3'b100;
  localparam logic [2:0] M_CLEAR  = 3'b101;
  localparam logic [2:0] M_SET    = 3'b110;
  localparam logic [2:0] M_ROTL   = 3'b111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [WIDTH-1:0] q_p0;
  logic             sout_p0;
  logic             chg_p0;

  // Next-state decode; Sin and D are only looked at by the modes that use them.
  always_comb begin
    q_p0    = Q;
    sout_p0 = Sout;
    unique case (Mode)
      M_HOLD:   q_p0 = Q;
      M_LOAD:   q_p0 = D;
      M_SHL: begin
        q_p0    = {Q[WIDTH-2:0], Sin};
        sout_p0 = Q[WIDTH-1];
      end
      M_SHR: begin
        q_p0    = {Sin, Q[WIDTH-1:1]};
        sout_p0 = Q[0];
      end
      M_TOGGLE: q_p0 = Q ^ D;
      M_CLEAR:  q_p0 = '0;
      M_SET:    q_p0 = '1;
      M_ROTL: begin
        q_p0    = {Q[WIDTH-2:0], Q[WIDTH-1]};
        sout_p0 = Q[WIDTH-1];
      end
      default:  q_p0 = Q;
    endcase
    chg_p0 = En && (q_p0 != Q);
  end

  // Register stage: reset wins over everything, En gates all updates.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Q       <= RESET_VAL;
      Sout    <= 1'b0;
      Changed <= 1'b0;
      Chg_cnt <= '0;
    end else begin
      Changed <= chg_p0;
      if (En) begin
        Q    <= q_p0;
        Sout <= sout_p0;
        if (chg_p0) Chg_cnt <= sat_inc(Chg_cnt);
      end
    end
  end

  assign Qb = ~Q;

endmodule

// File: tb/tb_dff_universal_reg.sv
// Bench for dff_universal_reg: directed scenarios plus a random soak, with a
// behavioural model feeding an expected-value queue checked after every edge.
module tb_dff_universal_reg;

  logic       Clk = 1'b0;
  logic       Rst_n, En, Sin;
  logic [2:0] Mode;
  logic [7:0] D;

  logic [7:0]  q, qb, q3, qb3;
  logic        sout, chg, sout3, chg3;
  logic [15:0] cnt;
  logic [2:0]  cnt3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  q;
    logic        sout;
    logic        chg;
    logic [15:0] cnt;
    logic [2:0]  cnt3;
  } exp_t;

  exp_t sbq[$];

  // behavioural model state
  logic [7:0]  m_q;
  logic        m_sout, m_chg;
  logic [15:0] m_cnt;
  logic [2:0]  m_cnt3;

  always #5 Clk = ~Clk;

  dff_universal_reg #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Mode(Mode), .D(D), .Sin(Sin),
    .Q(q), .Qb(qb), .Sout(sout), .Changed(chg), .Chg_cnt(cnt)
  );

  dff_universal_reg #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(3)) dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Mode(Mode), .D(D), .Sin(Sin),
    .Q(q3), .Qb(qb3), .Sout(sout3), .Changed(chg3), .Chg_cnt(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst_n, input logic en, input logic [2:0] mode,
                       input logic [7:0] d, input logic sin);
    logic [7:0] nq;
    logic       ns;
    exp_t       e;
    if (!rst_n) begin
      m_q = 8'h00; m_sout = 1'b0; m_chg = 1'b0; m_cnt = '0; m_cnt3 = '0;
    end else if (!en) begin
      m_chg = 1'b0;
    end else begin
      nq = m_q; ns = m_sout;
      case (mode)
        3'd1: nq = d;
        3'd2: begin nq = {m_q[6:0], sin}; ns = m_q[7]; end
        3'd3: begin nq = {sin, m_q[7:1]}; ns = m_q[0]; end
        3'd4: nq = m_q ^ d;
        3'd5: nq = 8'h00;
        3'd6: nq = 8'hFF;
        3'd7: begin nq = {m_q[6:0], m_q[7]}; ns = m_q[7]; end
        default: nq = m_q;
      endcase
      m_chg = (nq != m_q);
      if (m_chg) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt3 != 3'd7) m_cnt3 = m_cnt3 + 3'd1;
      end
      m_q = nq; m_sout = ns;
    end
    e.q = m_q; e.sout = m_sout; e.chg = m_chg; e.cnt = m_cnt; e.cnt3 = m_cnt3;
    sbq.push_back(e);
  endtask

  // Drive one edge's inputs, push the expectation, clock, then pop and compare.
  task automatic step(input logic rst_n, input logic en, input logic [2:0] mode,
                      input logic [7:0] d, input logic sin);
    exp_t e;
    Rst_n = rst_n; En = en; Mode = mode; D = d; Sin = sin;
    model(rst_n, en, mode, d, sin);
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    chk("q", {24'd0, q}, {24'd0, e.q});
    chk("qb", {24'd0, qb}, {24'd0, ~q});
    chk("sout", {31'd0, sout}, {31'd0, e.sout});
    chk("changed", {31'd0, chg}, {31'd0, e.chg});
    chk("chg_cnt", {16'd0, cnt}, {16'd0, e.cnt});
    chk("chg_cnt3", {29'd0, cnt3}, {29'd0, e.cnt3});
    chk("qb3", {24'd0, qb3}, {24'd0, ~q3});
  endtask

  initial begin
    Rst_n = 1'b0; En = 1'b1; Mode = 3'd1; D = 8'hAA; Sin = 1'b0;

    // reset for two edges while a load is requested
    step(1'b0, 1'b1, 3'd1, 8'hAA, 1'b0);
    step(1'b0, 1'b1, 3'd1, 8'hAA, 1'b0);
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_qb", {24'd0, qb}, 32'hFF);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    chk("rst_changed", {31'd0, chg}, 32'd0);

    // load, then hold with En=0
    step(1'b1, 1'b1, 3'd1, 8'h5A, 1'b0);
    chk("load_q", {24'd0, q}, 32'h5A);
    chk("load_qb", {24'd0, qb}, 32'hA5);
    chk("load_changed", {31'd0, chg}, 32'd1);
    chk("load_cnt", {16'd0, cnt}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd1, 8'hFF, 1'b1);
    chk("hold_q", {24'd0, q}, 32'h5A);
    chk("hold_changed", {31'd0, chg}, 32'd0);
    chk("hold_cnt", {16'd0, cnt}, 32'd1);

    // shifts and rotates
    step(1'b1, 1'b1, 3'd1, 8'h81, 1'b0);
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b0);
    chk("shl_q", {24'd0, q}, 32'h02);
    chk("shl_sout", {31'd0, sout}, 32'd1);
    step(1'b1, 1'b1, 3'd3, 8'h00, 1'b1);
    chk("shr_q", {24'd0, q}, 32'h81);
    chk("shr_sout", {31'd0, sout}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'd7, 8'h00, 1'b0);
    chk("rotl_q", {24'd0, q}, 32'h81);
    chk("rotl_cnt", {16'd0, cnt}, 32'd12);

    // toggle and no-change cases
    step(1'b1, 1'b1, 3'd1, 8'hF0, 1'b0);
    step(1'b1, 1'b1, 3'd4, 8'h00, 1'b0);
    chk("tog0_q", {24'd0, q}, 32'hF0);
    chk("tog0_changed", {31'd0, chg}, 32'd0);
    step(1'b1, 1'b1, 3'd4, 8'hFF, 1'b0);
    chk("togff_q", {24'd0, q}, 32'h0F);
    chk("togff_changed", {31'd0, chg}, 32'd1);
    step(1'b1, 1'b1, 3'd1, 8'h0F, 1'b0);
    chk("loadsame_changed", {31'd0, chg}, 32'd0);

    // saturation of the 3-bit counter, then reset clears it
    step(1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 3'd6 : 3'd5, 8'h00, 1'b0);
    chk("sat_cnt3", {29'd0, cnt3}, 32'd7);
    chk("sat_cnt16", {16'd0, cnt}, 32'd10);
    step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
    chk("sat_rst_cnt3", {29'd0, cnt3}, 32'd0);
    chk("sat_rst_q", {24'd0, q}, 32'h00);

    // random soak: 1000 edges at 10 ns
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(31) != 0), 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
